updown_counter: RTL

Parametrised synchronous binary counter that succeeds the fixed 4-bit 74LS161 model in the chip library. It adds configurable width and modulus, up/down counting, and a synchronous clear alongside the asynchronous one. It keeps the ENP/ENT/CO cascade scheme, so wide counters can still be built from several instances. It is intended for program counters, timers and address generators on the 8-bit datapath.

---
 rtl/updown_counter.sv | 97 +++++++++
 1 files changed

// File: rtl/updown_counter.sv
// updown_counter: parametrised synchronous up/down binary counter with
// configurable modulus, synchronous clear, parallel load and an ENP/ENT/CO
// cascade scheme compatible with the classic 161-style counter chain.
// TCP is a registered one-cycle pulse marking each wrap of the count range.
module updown_counter #(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             CLK,
    input  logic             CLRB,
    input  logic             SCLRB,
    input  logic             LOADB,
    input  logic [WIDTH-1:0] D,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             TCP
);

    // Comparisons run one bit wider than Q so that MODULUS = 2**WIDTH is
    // representable and an out-of-range loaded value is detectable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   TOP_EXT = (WIDTH+1)'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] TOP_VAL = TOP_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             tcp_reg;
    logic             tcp_next;

    logic [WIDTH:0]   q_ext;
    logic             below_top;
    logic             at_top;
    logic             at_zero;
    logic             in_range;

    assign q_ext     = {1'b0, q_reg};
    assign below_top = (q_ext < TOP_EXT);
    assign at_top    = (q_ext == TOP_EXT);
    assign at_zero   = (q_reg == '0);
    assign in_range  = (q_ext < MOD_EXT);

    // Next-state selection: sync clear, then load, then count step, else hold.
    always_comb begin
        q_next   = q_reg;
        tcp_next = 1'b0;
        if (!SCLRB) begin
            q_next = '0;
        end else if (!LOADB) begin
            // Loaded unmodified, even when D lies outside the count range.
            q_next = D;
        end else if (ENP && ENT) begin
            if (UP) begin
                if (below_top) begin
                    q_next = q_reg + ONE;
                end else begin
                    // Terminal value or any out-of-range value wraps to zero.
                    q_next   = '0;
                    tcp_next = 1'b1;
                end
            end else begin
                if (at_zero) begin
                    q_next   = TOP_VAL;
                    tcp_next = 1'b1;
                end else if (!in_range) begin
                    // Recover from an out-of-range load without flagging a wrap.
                    q_next = TOP_VAL;
                end else begin
                    q_next = q_reg - ONE;
                end
            end
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge CLK or negedge CLRB) begin
        if (!CLRB) begin
            q_reg   <= '0;
            tcp_reg <= 1'b0;
        end else begin
            q_reg   <= q_next;
            tcp_reg <= tcp_next;
        end
    end

    // Carry-out is purely combinational so a cascade ripples within one cycle.
    always_comb begin
        CO = ENT & (UP ? at_top : at_zero);
    end

    assign Q   = q_reg;
    assign TCP = tcp_reg;

endmodule
